// File: rtl/pixel_frame_reader.sv
// pixel_frame_reader: raster-order frame-buffer reader feeding a valid/ready pixel stream
module pixel_frame_reader #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_W     = 17
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [11:0]       i_mem_rdata,
  output logic [11:0]       o_pix_out,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_pix_sof,
  output logic              o_pix_eol
);
  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]        r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_fl_sof;
  logic              r_fl_eol;
  logic [13:0]       r_fifo [2];
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_cnt;
  logic              w_pop;
  logic              w_issue;
  logic              w_x_last;
  logic              w_y_last;
  logic              w_last_rd;
  logic              w_last_pop;
  logic              w_start;
  logic [13:0]       w_head;
  assign w_pop       = o_pix_valid & i_pix_ready;
  assign w_x_last    = r_x == XW'(IMG_WIDTH - 1);
  assign w_y_last    = r_y == YW'(IMG_HEIGHT - 1);
  assign w_start     = (r_state == IDLE) & i_start;
  assign w_issue     = (r_state == RUN) && (({1'b0, r_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));
  assign w_last_rd   = w_issue & w_x_last & w_y_last;
  assign w_last_pop  = (r_state == DRAIN) & w_pop & (r_cnt == 2'd1) & ~r_inflight;
  assign w_head      = r_fifo[r_rp];
  assign o_pix_valid = r_cnt != 2'd0;
  assign o_pix_out   = o_pix_valid ? w_head[11:0] : 12'd0;
  assign o_pix_sof   = o_pix_valid & w_head[13];
  assign o_pix_eol   = o_pix_valid & w_head[12];
  assign o_busy      = r_state != IDLE;
  assign o_done      = r_state == DONE;
  assign o_mem_rd_en = w_issue;
  assign o_mem_addr  = r_addr;
  // Frame sequencing: the last issued read ends RUN, the last accepted pixel ends DRAIN
  always_ff @(posedge i_clock)
    if (i_reset) r_state <= IDLE;
    else r_state <= w_start ? RUN : w_last_rd ? DRAIN : w_last_pop ? DONE : (r_state == DONE) ? IDLE : r_state;
  // Raster position of the next read; the address register stays on the last pixel once the frame is issued
  always_ff @(posedge i_clock)
    if (i_reset || w_start) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (w_issue) begin
      r_x    <= w_x_last ? '0 : r_x + 1'b1;
      r_y    <= w_x_last ? (w_y_last ? '0 : r_y + 1'b1) : r_y;
      r_addr <= w_last_rd ? r_addr : r_addr + 1'b1;
    end
  // Flags travel alongside the read so they meet the returning data one cycle later
  always_ff @(posedge i_clock)
    if (i_reset) begin
      r_inflight <= 1'b0;
      r_fl_sof   <= 1'b0;
      r_fl_eol   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_fl_sof   <= (r_x == '0) & (r_y == '0);
      r_fl_eol   <= w_x_last;
    end
  // Two-entry output FIFO; push and pop in the same cycle both take effect
  always_ff @(posedge i_clock)
    if (i_reset) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_fifo[r_wp] <= {r_fl_sof, r_fl_eol, i_mem_rdata};
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
endmodule

// File: tb/tb_pixel_frame_reader.sv
// tb_pixel_frame_reader: directed vectors plus scoreboarded multi-cycle sequences for the frame reader
module tb_pixel_frame_reader;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 17;
  typedef struct packed {
    logic        start;
    logic        ready;
    logic        valid;
    logic [11:0] pix;
    logic        sof;
    logic        eol;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [3:0]  addr;
  } vec_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          busy, done, rd_en, valid, sof, eol;
  logic [AW-1:0] addr;
  logic [11:0]   rdata = 12'hbad;
  logic [11:0]   pix;
  int            n_vec = 0;
  int            n_bad = 0;
  int            idx = 0;
  int            rd_idx = 0;
  int            issued = 0;
  int            accepted = 0;
  int            dones = 0;
  int            sofs = 0;
  logic          p_stall = 1'b0;
  logic          p_done = 1'b0;
  logic [13:0]   p_out = '0;
  vec_t          tbl [13];

  always #5 clk = ~clk;

  pixel_frame_reader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .o_busy(busy), .o_done(done),
    .o_mem_rd_en(rd_en), .o_mem_addr(addr), .i_mem_rdata(rdata),
    .o_pix_out(pix), .o_pix_valid(valid), .i_pix_ready(ready),
    .o_pix_sof(sof), .o_pix_eol(eol)
  );

  always @(posedge clk) rdata <= rd_en ? 12'(addr[11:0] * 12'h111) : 12'hbad;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit s, bit v, logic [11:0] p, bit sf, bit el, bit b, bit d, bit r, int a);
    return '{start: s, ready: 1'b1, valid: v, pix: p, sof: sf, eol: el, busy: b, done: d, rd_en: r, addr: 4'(a)};
  endfunction

  // Scoreboard: pixel order, flags, stall stability, read addresses, outstanding reads, frame completion
  always @(negedge clk) begin
    if (p_stall) chk("stall_hold", 32'({valid, sof, eol, pix}), 32'({1'b1, p_out}));
    if (p_done) chk("idle_after_done", 32'(busy), 32'(0));
    if (!valid) chk("flags_when_invalid", 32'({sof, eol}), 32'(0));
    if (rd_en) begin
      chk("rd_addr", 32'(addr), 32'(rd_idx));
      rd_idx = (rd_idx == W * H - 1) ? 0 : rd_idx + 1;
      issued++;
    end
    if (valid && ready) begin
      chk("pixel", 32'({sof, eol, pix}), 32'({idx == 0, (idx % W) == W - 1, 12'(idx * 12'h111)}));
      if (sof) sofs++;
      idx++;
      accepted++;
    end
    if (rd_en) chk("outstanding", 32'((issued - accepted) <= 2), 32'(1));
    if (done) begin
      chk("done_after_frame", 32'(idx), 32'(W * H));
      dones++;
      idx = 0;
    end
    p_stall = valid & !ready;
    p_out   = {sof, eol, pix};
    p_done  = done;
  end

  task automatic cyc(input logic s, input logic r, input logic rs);
    start = s;
    ready = r;
    rst   = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, i0, s0, k;
    tbl[0]  = mk(1, 0, 12'h000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 0);
    tbl[2]  = mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 1);
    tbl[3]  = mk(0, 1, 12'h000, 1, 0, 1, 0, 1, 2);
    tbl[4]  = mk(0, 1, 12'h111, 0, 0, 1, 0, 1, 3);
    tbl[5]  = mk(0, 1, 12'h222, 0, 0, 1, 0, 1, 4);
    tbl[6]  = mk(0, 1, 12'h333, 0, 1, 1, 0, 1, 5);
    tbl[7]  = mk(0, 1, 12'h444, 0, 0, 1, 0, 1, 6);
    tbl[8]  = mk(0, 1, 12'h555, 0, 0, 1, 0, 1, 7);
    tbl[9]  = mk(0, 1, 12'h666, 0, 0, 1, 0, 0, 7);
    tbl[10] = mk(0, 1, 12'h777, 0, 1, 1, 0, 0, 7);
    tbl[11] = mk(0, 0, 12'h000, 0, 0, 1, 1, 0, 7);
    tbl[12] = mk(0, 0, 12'h000, 0, 0, 0, 0, 0, 7);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Single frame with pix_ready held high, cycle-exact expectations
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].start;
      ready = tbl[i].ready;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'({valid, pix, sof, eol, busy, done, rd_en, addr[3:0]}), 32'(tbl[i][21:0]));
      @(posedge clk);
      #1;
    end
    // Ready pattern 1,0,0,1: same frame, no loss or duplication
    d0 = dones;
    k = 0;
    while (dones == d0 && k < 100) begin
      cyc(k == 0, (k % 4 == 0) || (k % 4 == 3), 1'b0);
      k++;
    end
    chk("stall_pattern_frames", 32'(dones - d0), 32'(1));
    cyc(1'b0, 1'b1, 1'b0);
    // Downstream blocked for 10 cycles: only two reads may be outstanding
    d0 = dones;
    i0 = issued;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("blocked_reads", 32'(issued - i0), 32'(2));
    chk("blocked_head", 32'({valid, sof, pix}), 32'({2'b11, 12'h000}));
    k = 0;
    while (dones == d0 && k < 50) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    chk("blocked_frames", 32'(dones - d0), 32'(1));
    cyc(1'b0, 1'b1, 1'b0);
    // Start re-pulsed mid-frame must be ignored
    d0 = dones;
    for (int i = 0; i < 30; i++) cyc(i == 0 || i == 4 || i == 7, 1'b1, 1'b0);
    chk("repulse_frames", 32'(dones - d0), 32'(1));
    chk("repulse_idle", 32'(busy), 32'(0));
    // Reset mid-frame with a read in flight, then restart immediately
    for (int i = 0; i < 6; i++) cyc(i == 0, 1'b1, 1'b0);
    chk("pre_reset_accepted", 32'(idx), 32'(3));
    cyc(1'b0, 1'b1, 1'b1);
    idx = 0;
    rd_idx = 0;
    issued = 0;
    accepted = 0;
    p_stall = 1'b0;
    start = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", 32'({valid, pix, sof, eol, busy, done, rd_en, addr}), 32'(0));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("post_reset_discard", 32'({valid, busy, rd_en, addr}), 32'({3'b011, 17'd0}));
    @(posedge clk);
    #1;
    d0 = dones;
    k = 0;
    while (dones == d0 && k < 50) begin
      cyc(1'b0, 1'b1, 1'b0);
      k++;
    end
    chk("restart_frames", 32'(dones - d0), 32'(1));
    cyc(1'b0, 1'b1, 1'b0);
    // Start held high: back-to-back frames, each opening with sof on 000
    d0 = dones;
    s0 = sofs;
    for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("held_start_frames", 32'(dones - d0), 32'(4));
    chk("held_start_sofs", 32'(sofs - s0), 32'(4));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pixel_frame_reader.md
PIXEL_FRAME_READER -- requirements
Module: pixel_frame_reader

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 320, meaning pixels per line (>=2).
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, meaning lines per frame (>=1).
REQ-003 SHALL have parameter ADDR_W, default 17, meaning frame-buffer address width (2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT).
REQ-004 SHALL have port: clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: start  input  1  frame request, sampled only in IDLE.
REQ-007 SHALL have port: busy  output  1  high from RUN entry until done pulse inclusive.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when last frame pixel is accepted downstream.
REQ-009 SHALL have port: mem_rd_en  output  1  frame-buffer read strobe.
REQ-010 SHALL have port: mem_addr  output  ADDR_W  read address, raster order, 0..IMG_WIDTH*IMG_HEIGHT-1.
REQ-011 SHALL have port: mem_rdata  input  12  read data, valid exactly one cycle after mem_rd_en.
REQ-012 SHALL have port: pix_out  output  12  pixel to the pixel operator's pixel_in.
REQ-013 SHALL have port: pix_valid  output  1  pix_out/pix_sof/pix_eol valid.
REQ-014 SHALL have port: pix_ready  input  1  downstream accept; transfer when pix_valid & pix_ready.
REQ-015 SHALL have port: pix_sof  output  1  high with the frame's first pixel (x=0,y=0).
REQ-016 SHALL have port: pix_eol  output  1  high with each line's last pixel (x=IMG_WIDTH-1).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when the last read is issued; DRAIN->DONE on acceptance of the last pixel; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL ignore start in RUN, DRAIN, DONE; no queuing of a second request.
REQ-019 SHALL hold an x counter (0..IMG_WIDTH-1) and y counter (0..IMG_HEIGHT-1) for issued reads; x wraps to 0 and y increments on x=IMG_WIDTH-1; mem_addr = y*IMG_WIDTH+x held in a separate incrementing register, not a multiplier.
REQ-020 SHALL buffer returned data in a 2-entry FIFO carrying {sof, eol, pixel}; pix_out/pix_valid driven from FIFO head; flags computed at issue time and pipelined with the read.
REQ-021 SHALL track one in-flight flag (read issued last cycle); issue a read in RUN only when occupancy + inflight - pop < 2, where pop = pix_valid & pix_ready.
REQ-022 SHALL write mem_rdata into the FIFO in the cycle after mem_rd_en; FIFO never overflows, write and pop in the same cycle both take effect.
REQ-023 SHALL sustain one pixel per cycle with pix_ready held high after initial latency.
REQ-024 SHALL give first-pixel latency of 3 cycles: start sampled cycle 0, mem_rd_en addr 0 cycle 1, FIFO write cycle 2, pix_valid cycle 3.
REQ-025 SHALL hold pix_out, pix_sof, pix_eol stable while pix_valid & !pix_ready.
REQ-026 SHALL deassert pix_valid when FIFO is empty; pix_sof/pix_eol SHALL be 0 whenever pix_valid is 0.
REQ-027 SHALL assert done in the DONE cycle; busy SHALL be 1 in RUN, DRAIN, DONE and 0 in IDLE.
REQ-028 SHALL drive mem_rd_en only in RUN; mem_addr holds last value otherwise.

Reset
REQ-029 SHALL, on reset high at a rising edge, regardless of state: state=IDLE, x=y=0, mem_addr=0, mem_rd_en=0, inflight=0, FIFO empty, pix_valid=0, pix_sof=0, pix_eol=0, pix_out=0, busy=0, done=0.
REQ-030 SHALL discard an in-flight read when reset occurs mid-frame; mem_rdata returning after reset SHALL NOT enter the FIFO.
REQ-031 SHALL accept start on the first cycle after reset deasserts.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, memory word[a]=a*12'h111)
REQ-032 SHALL cover: start pulse, pix_ready=1 -> pix_valid from cycle 3, pix_out 000,111,...,777 on 8 consecutive cycles, sof on 000, eol on 333 and 777, done one cycle after 777 accepted.
REQ-033 SHALL cover: pix_ready toggled 1,0,0,1 repeating -> same 8-pixel sequence, no loss/duplication, outputs stable during stalls, mem_rd_en never leaves >2 outstanding.
REQ-034 SHALL cover: pix_ready=0 for 10 cycles after start -> exactly 2 reads issued (addr 0,1), pix_out=000 held; release -> remaining 6 pixels follow in order.
REQ-035 SHALL cover: start re-pulsed during RUN -> ignored, exactly one frame and one done.
REQ-036 SHALL cover: reset asserted after 3 pixels accepted -> next cycle all outputs at REQ-029 values; new start -> frame restarts at 000 with sof.
REQ-037 SHALL cover: start held high continuously -> back-to-back frames separated by DONE and IDLE cycles, each frame beginning with sof on 000.
